// File: rtl/irq_arbiter.sv
// irq_arbiter: latches rising edges of interrupt sources as pending, masks them,
// picks one and raises a registered request to the control unit. Tracks the
// running handler so requests never nest and never fire while in kernel space.
// Optional macro IRQ_ROUND_ROBIN_EN: rotating priority starting at rr_ptr
// instead of fixed lowest-index priority.
module irq_arbiter #(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned CW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_wr,
    input  logic [N_SRC-1:0] mask_wdata,
    input  logic             pc_kernel,
    input  logic             irq_taken,
    input  logic             eret,
    output logic             irq_sig,
    output logic [CW-1:0]    irq_cause,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask,
    output logic             in_service
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] cause_oh;
    logic [N_SRC-1:0] clr;
    logic [CW-1:0]    cause_q, cause_d;
    logic [CW-1:0]    sel;
    logic             sig_q, sig_d;
    logic             insvc_q, insvc_d;
`ifdef IRQ_ROUND_ROBIN_EN
    logic [CW-1:0]    rr_q, rr_d;
    logic [CW-1:0]    hi_sel, wrap_sel;
    logic             hi_found;
`endif

    assign eligible = pending_q & mask_q;
    assign cause_oh = N_SRC'(1) << cause_q;

`ifdef IRQ_ROUND_ROBIN_EN
    // Rotating pick: lowest eligible index >= rr_q, else wrap to lowest eligible overall.
    always_comb begin
        hi_sel   = '0;
        wrap_sel = '0;
        hi_found = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                wrap_sel = CW'(i);
                if (CW'(i) >= rr_q) begin
                    hi_sel   = CW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        sel = hi_found ? hi_sel : wrap_sel;
    end
`else
    // Fixed pick: scanning downward leaves the lowest eligible index in sel.
    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel = CW'(i);
            end
        end
    end
`endif

    // Next-state and output decode for the request/service handshake.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        sig_d   = sig_q;
        insvc_d = insvc_q;
        clr     = '0;
`ifdef IRQ_ROUND_ROBIN_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if ((|eligible) && !pc_kernel && !eret) begin
                    state_d = StReq;
                    cause_d = sel;
                    sig_d   = 1'b1;
                end
            end
            StReq: begin
                // Acceptance beats withdrawal when both happen in one cycle.
                if (irq_taken) begin
                    clr     = cause_oh;
                    sig_d   = 1'b0;
                    insvc_d = 1'b1;
                    state_d = StService;
`ifdef IRQ_ROUND_ROBIN_EN
                    rr_d    = (cause_q == CW'(N_SRC - 1)) ? '0 : cause_q + 1'b1;
`endif
                end else if (!(|(mask_q & cause_oh)) || pc_kernel) begin
                    sig_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            StService: begin
                if (eret) begin
                    insvc_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh edge overrides a same-cycle clear, so no interrupt is lost.
    always_comb begin
        pending_d = (pending_q & ~clr) | (irq_src & ~src_q);
        mask_d    = mask_wr ? mask_wdata : mask_q;
    end

    // State, edge-detect, pending and mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            cause_q   <= '0;
            sig_q     <= 1'b0;
            insvc_q   <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= irq_src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            cause_q   <= cause_d;
            sig_q     <= sig_d;
            insvc_q   <= insvc_d;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign irq_sig    = sig_q;
    assign irq_cause  = cause_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign in_service = insvc_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the interrupt rules.
`timescale 1ns/1ps
module tb_irq_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;
`ifdef IRQ_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_src;
    logic          mask_wr;
    logic [N-1:0]  mask_wdata;
    logic          pc_kernel;
    logic          irq_taken;
    logic          eret;
    logic          irq_sig;
    logic [CW-1:0] irq_cause;
    logic [N-1:0]  pending;
    logic [N-1:0]  mask;
    logic          in_service;

    int total = 0;
    int bad   = 0;

    irq_arbiter #(.N_SRC(N), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .pc_kernel  (pc_kernel),
        .irq_taken  (irq_taken),
        .eret       (eret),
        .irq_sig    (irq_sig),
        .irq_cause  (irq_cause),
        .pending    (pending),
        .mask       (mask),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    logic [11:0] act;
    assign act = {irq_sig, irq_cause, pending, mask, in_service};

    // Behavioural model: a requesting flag, a servicing flag, chosen cause,
    // pending/mask sets and the previous source levels for edge detection.
    bit [N-1:0] m_pend, m_mask, m_prev;
    bit         m_req, m_svc;
    int         m_cause, m_rr;

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0;
        m_req = 1'b0; m_svc = 1'b0; m_cause = 0; m_rr = 0;
    endtask

    // First eligible index found searching upward from start, wrapping.
    function automatic int pick(input bit [N-1:0] elig, input int start);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (((elig >> idx) & N'(1)) != 0) return idx;
        end
        return 0;
    endfunction

    task automatic model_step();
        bit [N-1:0] rises;
        bit [N-1:0] clr;
        rises = irq_src & ~m_prev;
        clr   = '0;
        if (m_req) begin
            if (irq_taken) begin
                clr   = N'(1) << m_cause;
                m_req = 1'b0;
                m_svc = 1'b1;
                m_rr  = (m_cause + 1) % N;
            end else if ((((m_mask >> m_cause) & N'(1)) == 0) || pc_kernel) begin
                m_req = 1'b0;
            end
        end else if (m_svc) begin
            if (eret) m_svc = 1'b0;
        end else if ((m_pend & m_mask) != 0 && !pc_kernel && !eret) begin
            m_cause = pick(m_pend & m_mask, RR ? m_rr : 0);
            m_req   = 1'b1;
        end
        m_pend = (m_pend & ~clr) | rises;
        if (mask_wr) m_mask = mask_wdata;
        m_prev = irq_src;
    endtask

    function automatic logic [11:0] exp_vec();
        return {m_req, CW'(m_cause), m_pend, m_mask, m_svc};
    endfunction

    // One clock: model advances on the edge, outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        irq_src = '0; mask_wr = 1'b0; mask_wdata = '0;
        pc_kernel = 1'b0; irq_taken = 1'b0; eret = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_wr = 1'b1; mask_wdata = v;
        tick();
        mask_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        total++;
        if (act !== 12'b0) begin
            bad++; $display("FAIL reset_initial got=%h exp=000", act);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        write_mask(4'b1111);
        irq_src = 4'b0011;
        tick();
        irq_src = '0;
        tick();
        total++;
        if ({irq_sig, pending} !== {1'b1, 4'b0011}) begin
            bad++; $display("FAIL reset_setup_req got=%b_%b exp=1_0011", irq_sig, pending);
        end
        // Reset in the middle of a cycle while a request is outstanding.
        #2 reset = 1'b1;
        model_reset();
        #1;
        total++;
        if (act !== 12'b0) begin
            bad++; $display("FAIL reset_async got=%h exp=000", act);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        total++;
        if (act !== exp_vec()) begin
            bad++; $display("FAIL reset_idle_after got=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic test_basic();
        apply_reset();
        write_mask(4'b1111);
        irq_src = 4'b0100;
        tick();
        total++;
        if ({irq_sig, pending} !== {1'b0, 4'b0100}) begin
            bad++; $display("FAIL basic_pending got=%b_%b exp=0_0100", irq_sig, pending);
        end
        irq_src = '0;
        tick();
        total++;
        if ({irq_sig, irq_cause} !== {1'b1, 2'd2}) begin
            bad++; $display("FAIL basic_request got=%b_%0d exp=1_2", irq_sig, irq_cause);
        end
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
        total++;
        if ({irq_sig, pending, in_service} !== {1'b0, 4'b0000, 1'b1}) begin
            bad++; $display("FAIL basic_taken got=%b_%b_%b exp=0_0000_1", irq_sig, pending,
                            in_service);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        total++;
        if ({irq_sig, in_service} !== 2'b00 || act !== exp_vec()) begin
            bad++; $display("FAIL basic_eret got=%h exp=%h", act, exp_vec());
        end
    endtask

    task automatic serve_current();
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_priority();
        logic [CW-1:0] want;
        apply_reset();
        write_mask(4'b1111);
        irq_src = 4'b1010;
        tick();
        irq_src = '0;
        tick();
        total++;
        if ({irq_sig, irq_cause} !== {1'b1, 2'd1}) begin
            bad++; $display("FAIL prio_first got=%b_%0d exp=1_1", irq_sig, irq_cause);
        end
        serve_current();
        tick();
        total++;
        if ({irq_sig, irq_cause} !== {1'b1, 2'd3}) begin
            bad++; $display("FAIL prio_second got=%b_%0d exp=1_3", irq_sig, irq_cause);
        end
        serve_current();
        // Serve source 1 alone so a rotating pointer would land on 2.
        irq_src = 4'b0010;
        tick();
        irq_src = '0;
        tick();
        serve_current();
        irq_src = 4'b1010;
        tick();
        irq_src = '0;
        tick();
`ifdef IRQ_ROUND_ROBIN_EN
        want = 2'd3;
`else
        want = 2'd1;
`endif
        total++;
        if ({irq_sig, irq_cause} !== {1'b1, want} || act !== exp_vec()) begin
            bad++; $display("FAIL prio_rotate got=%b_%0d exp=1_%0d", irq_sig, irq_cause, want);
        end
        serve_current();
        tick();
        serve_current();
    endtask

    task automatic test_gating();
        apply_reset();
        write_mask(4'b1111);
        pc_kernel = 1'b1;
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        tick();
        tick();
        total++;
        if ({irq_sig, pending[0]} !== 2'b01) begin
            bad++; $display("FAIL gate_kernel got=%b_%b exp=0_1", irq_sig, pending[0]);
        end
        pc_kernel = 1'b0;
        tick();
        total++;
        if ({irq_sig, irq_cause} !== {1'b1, 2'd0}) begin
            bad++; $display("FAIL gate_release got=%b_%0d exp=1_0", irq_sig, irq_cause);
        end
        write_mask(4'b0000);
        tick();
        total++;
        if ({irq_sig, pending[0]} !== 2'b01 || act !== exp_vec()) begin
            bad++; $display("FAIL gate_mask_withdraw got=%h exp=%h", act, exp_vec());
        end
        write_mask(4'b1111);
        tick();
        pc_kernel = 1'b1;
        tick();
        total++;
        if ({irq_sig, pending[0]} !== 2'b01) begin
            bad++; $display("FAIL gate_kernel_withdraw got=%b_%b exp=0_1", irq_sig, pending[0]);
        end
        pc_kernel = 1'b0;
        tick();
        // Acceptance wins over a simultaneous kernel-mode withdraw.
        pc_kernel = 1'b1;
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
        pc_kernel = 1'b0;
        total++;
        if ({in_service, pending[0]} !== 2'b10 || act !== exp_vec()) begin
            bad++; $display("FAIL gate_taken_wins got=%h exp=%h", act, exp_vec());
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    task automatic test_no_nesting();
        apply_reset();
        write_mask(4'b1111);
        irq_src = 4'b0010;
        tick();
        irq_src = '0;
        tick();
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({irq_sig, pending[0], in_service} !== 3'b011) begin
                bad++; $display("FAIL nest_blocked cyc=%0d got=%b_%b_%b exp=0_1_1", i, irq_sig,
                                pending[0], in_service);
            end
        end
        write_mask(4'b0000);
        total++;
        if ({in_service, mask} !== {1'b1, 4'b0000}) begin
            bad++; $display("FAIL nest_mask_in_service got=%b_%b exp=1_0000", in_service, mask);
        end
        write_mask(4'b1111);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        total++;
        if ({irq_sig, in_service} !== 2'b00) begin
            bad++; $display("FAIL nest_eret got=%b_%b exp=0_0", irq_sig, in_service);
        end
        tick();
        total++;
        if ({irq_sig, irq_cause} !== {1'b1, 2'd0}) begin
            bad++; $display("FAIL nest_after_eret got=%b_%0d exp=1_0", irq_sig, irq_cause);
        end
        serve_current();
    endtask

    task automatic test_collision();
        apply_reset();
        write_mask(4'b1111);
        // Stray acceptance while idle must change nothing.
        irq_taken = 1'b1;
        tick();
        irq_taken = 1'b0;
        total++;
        if ({irq_sig, in_service} !== 2'b00 || act !== exp_vec()) begin
            bad++; $display("FAIL ignored_taken got=%h exp=%h", act, exp_vec());
        end
        irq_src = 4'b0010;
        tick();
        irq_src = '0;
        tick();
        irq_src = 4'b0010;
        irq_taken = 1'b1;
        tick();
        irq_src = '0;
        irq_taken = 1'b0;
        total++;
        if ({pending[1], in_service} !== 2'b11) begin
            bad++; $display("FAIL collision_set_wins got=%b_%b exp=1_1", pending[1], in_service);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
        total++;
        if ({irq_sig, irq_cause} !== {1'b1, 2'd1}) begin
            bad++; $display("FAIL collision_rerequest got=%b_%0d exp=1_1", irq_sig, irq_cause);
        end
        serve_current();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            irq_src    = irq_src ^ N'($urandom_range(0, 15) & $urandom_range(0, 15) &
                                      $urandom_range(0, 15));
            mask_wr    = ($urandom_range(0, 9) == 0);
            mask_wdata = N'($urandom_range(0, 15));
            pc_kernel  = ($urandom_range(0, 7) == 0);
            irq_taken  = ($urandom_range(0, 2) == 0);
            eret       = ($urandom_range(0, 3) == 0);
            tick();
            total++;
            if (act !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%h exp=%h", c, act, exp_vec());
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_gating();
        test_no_nesting();
        test_collision();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Collects external interrupt sources (timer, UART, switches), latches them as pending, masks them and picks one.
- Drives the single IRQ request into the main control unit, which forces the interrupt PC (PCsrc=5) and writes the return address to $k0 (RegDst=3, MemtoReg=2).
- Tracks the in-service handler, so there are no nested interrupts and no request while the PC is in kernel space (PC[31]=1).

Parameters:
- N_SRC, 4, number of interrupt sources (2..8).
- CW, 2, cause-code width; must satisfy 2**CW >= N_SRC.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- irq_src  input  N_SRC  raw level interrupt lines, synchronous to clk.
- mask_wr  input  1  write strobe for the enable mask.
- mask_wdata  input  N_SRC  new enable mask; bit=1 enables that source.
- pc_kernel  input  1  PC[31] of the current instruction.
- irq_taken  input  1  control unit applied the IRQ override this cycle.
- eret  input  1  handler return: kernel-to-user jr executed this cycle.
- irq_sig  output  1  registered interrupt request to the control unit.
- irq_cause  output  CW  index of the requested/in-service source.
- pending  output  N_SRC  latched pending bits, readable by software.
- mask  output  N_SRC  current enable mask.
- in_service  output  1  a handler is running.

Behaviour:
- Reset (async, immediate): state=IDLE; irq_sig=0, irq_cause=0, pending=0, mask=0 (all disabled), in_service=0, edge-detect registers=0.
- Edge detect: src_d <= irq_src each cycle. A rising edge (irq_src & ~src_d) sets pending[i] on that clock. Pending bits latch regardless of mask.
- Mask: on mask_wr, mask <= mask_wdata at the clock edge. The new value is used from the next cycle.
- Eligible set E = pending & mask.
- Selection: fixed priority, lowest index wins.

State machine:
- IDLE:
  - Condition for a request: E!=0 and pc_kernel=0 and eret=0.
  - When met: go to REQ; irq_cause <= selected index; irq_sig <= 1.
  - Latency: an edge on irq_src at clock n sets pending at n; irq_sig is high after clock n+1.
- REQ:
  - irq_sig=1 and irq_cause is frozen.
  - On irq_taken: clear pending[irq_cause]; irq_sig <= 0; in_service <= 1; go to SERVICE.
  - Withdraw: if mask[irq_cause] reads 0 or pc_kernel=1 and irq_taken=0, then irq_sig <= 0 and go to IDLE. The pending bit is kept.
  - irq_taken has priority over withdraw in the same cycle.
- SERVICE:
  - irq_sig=0 and no arbitration (no nesting).
  - On eret: in_service <= 0; go to IDLE. A new request can be raised no earlier than the cycle after IDLE is entered.

Boundary conditions:
- Rising edge on source i in the same cycle its pending bit is cleared: the set wins and pending[i] stays 1.
- irq_taken outside REQ and eret outside SERVICE are ignored; no state change.
- Multiple edges while pending: collapse into one pending bit.
- Edges keep latching in every state.
- mask_wr with all zeros while in SERVICE: no effect on the current handler.

Optional Feature:
- Macro: IRQ_ROUND_ROBIN_EN.
- Defined:
  - Add a CW-bit pointer rr_ptr, reset 0.
  - Selection takes the first eligible index starting at rr_ptr, searching upward with wrap-around modulo N_SRC.
  - On irq_taken, rr_ptr <= (irq_cause+1) mod N_SRC.
- Undefined: fixed lowest-index priority; no pointer register.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset mid-REQ with pending=4'b0011.
  - Required: all outputs 0 immediately, state IDLE, mask=0.
- Basic service:
  - Stimulus: mask=4'b1111; pulse irq_src[2] at clock n; pc_kernel=0.
  - Required: pending=4'b0100 at n; irq_sig=1 and irq_cause=2 after n+1.
  - Then irq_taken: pending=0, in_service=1, irq_sig=0; then eret: in_service=0.
- Priority:
  - Stimulus: edges on sources 3 and 1 in the same cycle, mask=4'b1111.
  - Required, fixed priority: cause=1 first; after eret, cause=3.
  - Required with IRQ_ROUND_ROBIN_EN and rr_ptr=2: cause=3 first.
- Kernel and mask gating:
  - pending[0]=1 with pc_kernel=1 → irq_sig stays 0.
  - In REQ, write mask=0 → irq_sig drops next cycle and pending[0] stays 1.
- No nesting:
  - Stimulus: in SERVICE, edge on source 0 with mask enabled.
  - Required: pending[0]=1 but irq_sig=0 until eret; after eret, irq_sig=1 one cycle later.
- Set/clear collision:
  - Stimulus: irq_taken for cause=1 in the same cycle as a new rising edge on irq_src[1].
  - Required: pending[1]=1 afterwards.
